// File: rtl/system_avalon_pkg.sv
// Shared definitions for Avalon-MM initiators: transfer FSM encoding, idle strobe
// levels and the sizing rule for the shared timeout / read-latency counter.
package system_avalon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_RWAIT = 2'd2,
    ST_RESP  = 2'd3
  } av_state_t;

  typedef struct packed {
    logic chipselect;
    logic write_n;
    logic read_n;
  } av_strobe_t;

  localparam av_strobe_t AV_IDLE = '{chipselect: 1'b0, write_n: 1'b1, read_n: 1'b1};

  // One counter must hold both the timeout count and the read-latency count.
  function automatic int cnt_width(input int timeout, input int latency);
    int bits_to;
    int bits_rl;
    int bits;
    bits_to = $clog2(timeout + 1);
    bits_rl = $clog2(latency + 1);
    bits    = (bits_to > bits_rl) ? bits_to : bits_rl;
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/system_avalon_pio_master.sv
// Avalon-MM initiator for PIO slaves: one read or write transfer per accepted command,
// with waitrequest handling, fixed read latency, timeout abort and one response per command.
module system_avalon_pio_master
  import system_avalon_pkg::*;
#(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] av_address,
  output logic              av_chipselect,
  output logic              av_write_n,
  output logic              av_read_n,
  output logic [DATA_W-1:0] av_writedata,
  input  logic [DATA_W-1:0] av_readdata,
  input  logic              av_waitrequest
);

  localparam int CNT_W = cnt_width(TIMEOUT, READ_LATENCY);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] RL_LAST = CNT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  av_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_error;
  av_strobe_t        r_strobe;
  logic [ADDR_W-1:0] r_av_address;
  logic [DATA_W-1:0] r_av_writedata;

  av_state_t         w_state_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_write_next;
  logic              w_cmd_ready_next;
  logic              w_rsp_valid_next;
  logic [DATA_W-1:0] w_rsp_rdata_next;
  logic              w_rsp_error_next;
  av_strobe_t        w_strobe_next;
  logic [ADDR_W-1:0] w_address_next;
  logic [DATA_W-1:0] w_wdata_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_write        <= 1'b0;
      r_cmd_ready    <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= '0;
      r_rsp_error    <= 1'b0;
      r_strobe       <= AV_IDLE;
      r_av_address   <= '0;
      r_av_writedata <= '0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_write        <= w_write_next;
      r_cmd_ready    <= w_cmd_ready_next;
      r_rsp_valid    <= w_rsp_valid_next;
      r_rsp_rdata    <= w_rsp_rdata_next;
      r_rsp_error    <= w_rsp_error_next;
      r_strobe       <= w_strobe_next;
      r_av_address   <= w_address_next;
      r_av_writedata <= w_wdata_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_write_next     = r_write;
    w_rsp_valid_next = 1'b0;
    w_rsp_rdata_next = r_rsp_rdata;
    w_rsp_error_next = r_rsp_error;
    w_strobe_next    = r_strobe;
    w_address_next   = r_av_address;
    w_wdata_next     = r_av_writedata;

    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_state_next   = ST_XFER;
          w_cnt_next     = '0;
          w_write_next   = cmd_write;
          w_address_next = cmd_address;
          w_wdata_next   = cmd_wdata;
          w_strobe_next  = '{chipselect: 1'b1, write_n: ~cmd_write, read_n: cmd_write};
        end
      end
      ST_XFER: begin
        // Completion is checked first, so it beats a timeout reached on the same edge.
        if (!av_waitrequest) begin
          w_strobe_next = AV_IDLE;
          w_cnt_next    = '0;
          if (r_write || READ_LATENCY == 0) begin
            w_state_next     = ST_RESP;
            w_rsp_valid_next = 1'b1;
            w_rsp_error_next = 1'b0;
            w_rsp_rdata_next = r_write ? '0 : av_readdata;
          end else begin
            w_state_next = ST_RWAIT;
          end
        end else if (TIMEOUT != 0 && r_cnt == TO_LAST) begin
          w_strobe_next    = AV_IDLE;
          w_state_next     = ST_RESP;
          w_rsp_valid_next = 1'b1;
          w_rsp_error_next = 1'b1;
          w_rsp_rdata_next = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_RWAIT: begin
        if (r_cnt == RL_LAST) begin
          w_state_next     = ST_RESP;
          w_rsp_valid_next = 1'b1;
          w_rsp_error_next = 1'b0;
          w_rsp_rdata_next = av_readdata;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next  = ST_IDLE;
        w_strobe_next = AV_IDLE;
      end
    endcase

    w_cmd_ready_next = (w_state_next == ST_IDLE);
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_error     = r_rsp_error;
  assign av_address    = r_av_address;
  assign av_chipselect = r_strobe.chipselect;
  assign av_write_n    = r_strobe.write_n;
  assign av_read_n     = r_strobe.read_n;
  assign av_writedata  = r_av_writedata;

endmodule

// File: tb/tb_system_avalon_pio_master.sv
// Two initiators (READ_LATENCY 0 and 2, TIMEOUT 8) against small PIO/register slaves,
// checked every cycle against a transaction-level timing model.
module tb_system_avalon_pio_master;

  localparam int NI = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b1;
  logic        cmd_valid      [NI];
  logic        cmd_ready      [NI];
  logic        cmd_write      [NI];
  logic [1:0]  cmd_address    [NI];
  logic [31:0] cmd_wdata      [NI];
  logic        rsp_valid      [NI];
  logic [31:0] rsp_rdata      [NI];
  logic        rsp_error      [NI];
  logic [1:0]  av_address     [NI];
  logic        av_chipselect  [NI];
  logic        av_write_n     [NI];
  logic        av_read_n      [NI];
  logic [31:0] av_writedata   [NI];
  logic [31:0] av_readdata    [NI];
  logic        av_waitrequest [NI];

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      system_avalon_pio_master #(
        .ADDR_W(2), .DATA_W(32), .READ_LATENCY(2 * gi), .TIMEOUT(TO)
      ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid[gi]), .cmd_ready(cmd_ready[gi]), .cmd_write(cmd_write[gi]),
        .cmd_address(cmd_address[gi]), .cmd_wdata(cmd_wdata[gi]),
        .rsp_valid(rsp_valid[gi]), .rsp_rdata(rsp_rdata[gi]), .rsp_error(rsp_error[gi]),
        .av_address(av_address[gi]), .av_chipselect(av_chipselect[gi]),
        .av_write_n(av_write_n[gi]), .av_read_n(av_read_n[gi]),
        .av_writedata(av_writedata[gi]), .av_readdata(av_readdata[gi]),
        .av_waitrequest(av_waitrequest[gi])
      );
    end
  endgenerate

  // Slaves: instance 0 is a 1-bit PIO output at address 0; instance 1 is a 4-word
  // register file whose read data appears two edges after the accepted read strobe.
  logic        pio_out = 1'b0;
  logic [31:0] mem [4] = '{default: 32'h0};
  logic [31:0] rd_pipe [2];
  always @(posedge clk) begin
    if (av_chipselect[0] && !av_write_n[0] && !av_waitrequest[0] && av_address[0] == 2'd0)
      pio_out <= av_writedata[0][0];
    if (av_chipselect[1] && !av_write_n[1] && !av_waitrequest[1])
      mem[av_address[1]] <= av_writedata[1];
    rd_pipe[0] <= (av_chipselect[1] && !av_read_n[1] && !av_waitrequest[1]) ? mem[av_address[1]] : $urandom;
    rd_pipe[1] <= rd_pipe[0];
  end
  always_comb begin
    av_readdata[0] = (av_address[0] == 2'd0) ? {31'b0, pio_out} : 32'h0;
    av_readdata[1] = rd_pipe[1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input int i, input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %h, expected %h", name, i, cyc, got, exp);
    end
  endtask

  // Model: per instance, the one outstanding transfer as cycle intervals.
  // ta = first strobe cycle, ts = strobe cycles, tr = response cycle.
  bit          act  [NI] = '{default: 1'b0};
  int          ta   [NI];
  int          ts   [NI];
  int          tr   [NI];
  bit          twr  [NI];
  logic [1:0]  tadr [NI];
  logic [31:0] tdat [NI];
  logic [31:0] texp [NI];
  bit          terr [NI];
  int          rdy_from [NI] = '{default: 1 << 30};
  bit          mdl_out = 1'b0;
  logic [31:0] mdl_mem [4] = '{default: 32'h0};
  logic [31:0] last_rd  [NI] = '{default: 32'h0};
  bit          last_err [NI] = '{default: 1'b0};

  function automatic bit model_ready(input int i, input int c);
    return (reset_n === 1'b1) && c >= rdy_from[i] && !(act[i] && c >= ta[i] && c <= tr[i]);
  endfunction

  function automatic logic [31:0] model_read(input int i, input logic [1:0] a);
    if (i == 0) return (a == 2'd0) ? {31'b0, mdl_out} : 32'h0;
    return mdl_mem[a];
  endfunction

  // The single per-cycle compare process.
  always @(negedge clk) begin : p_check
    bit win;
    bit rsp;
    for (int i = 0; i < NI; i++) begin
      if (reset_n !== 1'b1) begin
        chk(i, "rst_cmd_ready", cmd_ready[i], 0);
        chk(i, "rst_chipselect", av_chipselect[i], 0);
        chk(i, "rst_write_n", av_write_n[i], 1);
        chk(i, "rst_read_n", av_read_n[i], 1);
        chk(i, "rst_rsp_valid", rsp_valid[i], 0);
        chk(i, "rst_address", av_address[i], 0);
        chk(i, "rst_writedata", av_writedata[i], 0);
        chk(i, "rst_rsp_rdata", rsp_rdata[i], 0);
        chk(i, "rst_rsp_error", rsp_error[i], 0);
        last_rd[i]  = 32'h0;
        last_err[i] = 1'b0;
      end else begin
        win = act[i] && cyc >= ta[i] && cyc < ta[i] + ts[i];
        rsp = act[i] && cyc == tr[i];
        chk(i, "cmd_ready", cmd_ready[i], model_ready(i, cyc));
        chk(i, "chipselect", av_chipselect[i], win);
        chk(i, "write_n", av_write_n[i], !(win && twr[i]));
        chk(i, "read_n", av_read_n[i], !(win && !twr[i]));
        if (win) begin
          chk(i, "address", av_address[i], tadr[i]);
          if (twr[i]) chk(i, "writedata", av_writedata[i], tdat[i]);
        end
        chk(i, "rsp_valid", rsp_valid[i], rsp);
        if (rsp) begin
          last_rd[i]  = texp[i];
          last_err[i] = terr[i];
        end
        chk(i, "rsp_rdata", rsp_rdata[i], last_rd[i]);
        chk(i, "rsp_error", rsp_error[i], last_err[i]);
      end
    end
  end

  // Observation counters used by the hand-computed checks.
  int          cs_cnt  [NI] = '{default: 0};
  int          rsp_cnt [NI] = '{default: 0};
  int          rsp_cyc [NI] = '{default: 0};
  logic [31:0] rsp_dat [NI];
  logic        rsp_err [NI];
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (av_chipselect[i] === 1'b1) cs_cnt[i] <= cs_cnt[i] + 1;
      if (rsp_valid[i] === 1'b1) begin
        rsp_cnt[i] <= rsp_cnt[i] + 1;
        rsp_cyc[i] <= cyc;
        rsp_dat[i] <= rsp_rdata[i];
        rsp_err[i] <= rsp_error[i];
      end
    end
  end

  // Called at posedge+1. w = waitrequest-high cycles before completion;
  // abort_k >= 0 pulses reset in that strobe cycle and leaves a read held pending.
  task automatic issue(input int i, input bit wr, input logic [1:0] a, input logic [31:0] d,
                       input int w, input int abort_k);
    int  guard;
    int  s;
    bit  err;
    guard          = 0;
    cmd_valid[i]   = 1'b1;
    cmd_write[i]   = wr;
    cmd_address[i] = a;
    cmd_wdata[i]   = d;
    while (!model_ready(i, cyc)) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 200) begin
        checks++; errors++;
        $display("FAIL accept_bound inst%0d: no acceptance within 200 cycles", i);
        cmd_valid[i] = 1'b0;
        return;
      end
    end
    err     = (w >= TO);
    s       = err ? TO : w + 1;
    ta[i]   = cyc + 1;
    ts[i]   = s;
    tr[i]   = ta[i] + s + ((!wr && !err) ? 2 * i : 0);
    twr[i]  = wr;
    tadr[i] = a;
    tdat[i] = d;
    terr[i] = err;
    texp[i] = (wr || err) ? 32'h0 : model_read(i, a);
    if (wr && !err) begin
      if (i == 0) begin
        if (a == 2'd0) mdl_out = d[0];
      end else begin
        mdl_mem[a] = d;
      end
    end
    act[i] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[i]   = 1'b0;
    cmd_write[i]   = 1'($urandom_range(0, 1));
    cmd_address[i] = 2'($urandom_range(0, 3));
    cmd_wdata[i]   = $urandom;
    for (int k = 0; k < s; k++) begin
      if (k == abort_k) begin
        reset_n = 1'b0;
        #1;
        chk(i, "async_strobe_drop", av_chipselect[i], 0);
        for (int j = 0; j < NI; j++) act[j] = 1'b0;
        cmd_valid[i]   = 1'b1;
        cmd_write[i]   = 1'b0;
        cmd_address[i] = 2'd0;
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int j = 0; j < NI; j++) rdy_from[j] = cyc + 1;
        return;
      end
      av_waitrequest[i] = (k < w);
      @(posedge clk); #1;
    end
    av_waitrequest[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int i);
    int guard;
    guard = 0;
    while (act[i] && cyc <= tr[i]) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 100) begin
        checks++; errors++;
        $display("FAIL done_bound inst%0d: response window not reached in 100 cycles", i);
        return;
      end
    end
  endtask

  task automatic run(input int i, input bit wr, input logic [1:0] a, input logic [31:0] d, input int w);
    issue(i, wr, a, d, w, -1);
    wait_done(i);
  endtask

  int c0;
  int n0;
  int ri;
  int rr;
  int rw;

  initial begin
    for (int i = 0; i < NI; i++) begin
      cmd_valid[i]      = 1'b0;
      cmd_write[i]      = 1'b0;
      cmd_address[i]    = 2'd0;
      cmd_wdata[i]      = 32'h0;
      av_waitrequest[i] = 1'b0;
    end
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int j = 0; j < NI; j++) rdy_from[j] = cyc + 1;

    // Write 1 to the PIO, zero wait.
    c0 = cs_cnt[0]; n0 = rsp_cnt[0];
    run(0, 1'b1, 2'd0, 32'h0000_0001, 0);
    chk(0, "wr_strobe_cycles", cs_cnt[0] - c0, 1);
    chk(0, "wr_rsp_count", rsp_cnt[0] - n0, 1);
    chk(0, "wr_rsp_latency", rsp_cyc[0] - ta[0], 1);
    chk(0, "wr_rsp_error", rsp_err[0], 0);
    chk(0, "pio_out_set", {31'b0, pio_out}, 1);

    run(0, 1'b0, 2'd0, 32'h0, 0);
    chk(0, "rd_addr0", rsp_dat[0], 32'h0000_0001);
    run(0, 1'b0, 2'd1, 32'h0, 0);
    chk(0, "rd_addr1", rsp_dat[0], 32'h0000_0000);

    // Three waitrequest cycles.
    c0 = cs_cnt[0]; n0 = rsp_cnt[0];
    run(0, 1'b1, 2'd0, 32'hFFFF_FFFE, 3);
    chk(0, "wait3_strobe_cycles", cs_cnt[0] - c0, 4);
    chk(0, "wait3_rsp_count", rsp_cnt[0] - n0, 1);
    chk(0, "wait3_rsp_error", rsp_err[0], 0);
    chk(0, "pio_out_clr", {31'b0, pio_out}, 0);

    // Waitrequest stuck high: timeout after 8 strobe cycles.
    c0 = cs_cnt[0]; n0 = rsp_cnt[0];
    run(0, 1'b1, 2'd0, 32'h0000_0001, 40);
    chk(0, "to_strobe_cycles", cs_cnt[0] - c0, 8);
    chk(0, "to_rsp_count", rsp_cnt[0] - n0, 1);
    chk(0, "to_rsp_error", rsp_err[0], 1);
    chk(0, "to_rsp_rdata", rsp_dat[0], 0);
    chk(0, "to_pio_unchanged", {31'b0, pio_out}, 0);
    run(0, 1'b0, 2'd0, 32'h0, 0);
    chk(0, "after_to_latency", rsp_cyc[0] - ta[0], 1);
    chk(0, "after_to_rdata", rsp_dat[0], 0);

    // Read latency 2 on instance 1.
    run(1, 1'b1, 2'd2, 32'hA5A5_A5A5, 0);
    c0 = cs_cnt[1];
    run(1, 1'b0, 2'd2, 32'h0, 0);
    chk(1, "rl2_strobe_cycles", cs_cnt[1] - c0, 1);
    chk(1, "rl2_rdata", rsp_dat[1], 32'hA5A5_A5A5);
    chk(1, "rl2_latency", rsp_cyc[1] - ta[1], 3);

    // Reset during XFER, then a read held across reset is taken once.
    n0 = rsp_cnt[0];
    issue(0, 1'b1, 2'd0, 32'h0000_0001, 50, 2);
    c0 = cs_cnt[0];
    run(0, 1'b0, 2'd0, 32'h0, 0);
    chk(0, "rst_rsp_count", rsp_cnt[0] - n0, 1);
    chk(0, "rst_held_strobes", cs_cnt[0] - c0, 1);
    chk(0, "rst_held_rdata", rsp_dat[0], 0);

    // Randomized traffic across both instances.
    for (int n = 0; n < 200; n++) begin
      ri = $urandom_range(0, 1);
      rr = $urandom_range(0, 9);
      rw = (rr < 6) ? 0 : (rr < 9) ? $urandom_range(1, 4) : $urandom_range(8, 12);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
      issue(ri, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, rw, -1);
    end
    wait_done(0);
    wait_done(1);
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
